// File: rtl/i40xx_pkg.sv
// Shared definitions for the i40xx program sequencer slice.
// Holds the PC command encodings, the RUN/STOPPED state type and a small
// helper that tells whether a command behaves as a plain increment.
package i40xx_pkg;

  // PC command applied at the instruction-cycle boundary.
  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_CALL     = 3'd2,
    OP_RET      = 3'd3,
    OP_HOLD     = 3'd4,
    OP_PAGE     = 3'd5,
    OP_RETI     = 3'd6,
    OP_NEXT_ALT = 3'd7
  } pc_op_e;

  // Sequencer run state.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } seq_state_e;

  // Encodings 0 and 7 both advance the PC by one.
  function automatic logic op_is_next(input pc_op_e op);
    return (op == OP_NEXT) || (op == OP_NEXT_ALT);
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address stack for the i40xx sequencer.
// Entries are kept oldest-at-index-0; the top of stack is entry sp-1.
// A push into a full stack drops the oldest entry and raises ovf for that
// edge; a pop from an empty stack returns 0 and raises unf.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, pop       one-edge commands (never asserted together)
//   data            value to push
//   top             current top entry (0 when empty)
//   sp              occupancy 0..DEPTH
//   ovf, unf        combinational error strobes for the current command
module pc_stack #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data,
  output logic [ADDR_W-1:0] top,
  output logic [3:0]        sp,
  output logic              ovf,
  output logic              unf
);

  logic [DEPTH*ADDR_W-1:0] mem;
  logic [DEPTH*ADDR_W-1:0] mem_nx;
  logic [3:0]              sp_nx;
  logic                    full;
  logic                    empty;

  assign full  = (sp == 4'(DEPTH));
  assign empty = (sp == 4'd0);
  assign ovf   = push & full;
  assign unf   = pop & ~push & empty;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == 4'(i + 1)) top = mem[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    mem_nx = mem;
    sp_nx  = sp;
    if (push) begin
      if (full) begin
        // Shift everything one slot toward the bottom, losing the oldest.
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_nx[i*ADDR_W +: ADDR_W] = mem[(i+1)*ADDR_W +: ADDR_W];
        end
        mem_nx[(DEPTH-1)*ADDR_W +: ADDR_W] = data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sp == 4'(i)) mem_nx[i*ADDR_W +: ADDR_W] = data;
        end
        sp_nx = sp + 4'd1;
      end
    end else if (pop && !empty) begin
      sp_nx = sp - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
      sp  <= 4'd0;
    end else begin
      mem <= mem_nx;
      sp  <= sp_nx;
    end
  end

endmodule

// File: rtl/i4040_sequencer.sv
// i4040-style instruction sequencer.
// Runs a fixed NSUB = ANIB+5 subcycle instruction cycle (address nibbles,
// two memory subcycles, three execute subcycles). All PC, stack, interrupt
// and run-state decisions happen only on the boundary edge, i.e. the edge
// leaving the last subcycle.
// Ports:
//   clk, reset        subcycle clock, asynchronous active-low reset
//   pc_op, target     PC command and its destination, sampled at boundary
//   intr, stop        level interrupt and stop requests
//   clr_err           clears the sticky stack flags on any edge
//   sync, sub_idx     boundary marker and current subcycle
//   addr_nib          PC nibble during address subcycles, else 0
//   pc, sp            program counter and stack occupancy
//   int_en, int_ack   interrupt enable and one-cycle entry acknowledge
//   stop_ack          high while STOPPED
//   stack_ovf/unf     sticky stack error flags
module i4040_sequencer
  import i40xx_pkg::*;
#(
  parameter int ANIB    = 3,
  parameter int DEPTH   = 7,
  parameter int INT_VEC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pc_op,
  input  logic [4*ANIB-1:0] target,
  input  logic              intr,
  input  logic              stop,
  input  logic              clr_err,
  output logic              sync,
  output logic [2:0]        sub_idx,
  output logic [3:0]        addr_nib,
  output logic [4*ANIB-1:0] pc,
  output logic [3:0]        sp,
  output logic              int_en,
  output logic              int_ack,
  output logic              stop_ack,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int                ADDR_W    = 4 * ANIB;
  localparam int                NSUB      = ANIB + 5;
  localparam logic [3:0]        LAST      = 4'(NSUB - 1);
  localparam logic [ADDR_W-1:0] VEC       = ADDR_W'(INT_VEC);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(8'hFF);

  // Four bits so the counter still reaches NSUB-1 when ANIB=4.
  logic [3:0]        sub_cnt;
  seq_state_e        state;
  logic              boundary;
  pc_op_e            op;
  logic [ADDR_W-1:0] pc_inc;

  logic [ADDR_W-1:0] pc_nx;
  logic              int_en_nx;
  logic              int_ack_nx;
  seq_state_e        state_nx;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] stk_top;
  logic              ovf_s;
  logic              unf_s;

  assign boundary = (sub_cnt == LAST);
  assign op       = pc_op_e'(pc_op);
  assign pc_inc   = pc + ADDR_W'(1);
  assign sync     = boundary;
  assign sub_idx  = sub_cnt[2:0];
  assign stop_ack = (state == ST_STOPPED);

  always_comb begin
    addr_nib = 4'd0;
    for (int k = 0; k < ANIB; k++) begin
      if (sub_cnt == 4'(k)) addr_nib = pc[4*k +: 4];
    end
  end

  // Boundary decision. An accepted interrupt preempts both the PC command
  // and the stop request; the return address is the PC the command would
  // otherwise have produced.
  always_comb begin
    pc_nx      = pc;
    int_en_nx  = int_en;
    int_ack_nx = int_ack;
    state_nx   = state;
    push       = 1'b0;
    pop        = 1'b0;
    push_data  = pc_inc;
    if (boundary) begin
      int_ack_nx = 1'b0;
      if (state == ST_STOPPED) begin
        if (intr && int_en) begin
          push       = 1'b1;
          push_data  = pc;
          pc_nx      = VEC;
          int_en_nx  = 1'b0;
          int_ack_nx = 1'b1;
          state_nx   = ST_RUN;
        end else if (!stop) begin
          state_nx = ST_RUN;
        end
      end else if (intr && int_en && (op_is_next(op) || op == OP_HOLD)) begin
        push       = 1'b1;
        push_data  = (op == OP_HOLD) ? pc : pc_inc;
        pc_nx      = VEC;
        int_en_nx  = 1'b0;
        int_ack_nx = 1'b1;
      end else begin
        case (op)
          OP_NEXT, OP_NEXT_ALT: pc_nx = pc_inc;
          OP_JUMP:              pc_nx = target;
          OP_CALL: begin
            push  = 1'b1;
            pc_nx = target;
          end
          OP_RET: begin
            pop   = 1'b1;
            pc_nx = stk_top;
          end
          OP_HOLD:              pc_nx = pc;
          OP_PAGE:              pc_nx = (pc & ~PAGE_MASK) | (target & PAGE_MASK);
          OP_RETI: begin
            pop       = 1'b1;
            pc_nx     = stk_top;
            int_en_nx = 1'b1;
          end
          default:              pc_nx = pc;
        endcase
        if (stop) state_nx = ST_STOPPED;
      end
    end
  end

  pc_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (push_data),
    .top   (stk_top),
    .sp    (sp),
    .ovf   (ovf_s),
    .unf   (unf_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt   <= 4'd0;
      state     <= ST_RUN;
      pc        <= '0;
      int_en    <= 1'b0;
      int_ack   <= 1'b0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      sub_cnt   <= boundary ? 4'd0 : sub_cnt + 4'd1;
      state     <= state_nx;
      pc        <= pc_nx;
      int_en    <= int_en_nx;
      int_ack   <= int_ack_nx;
      // A new error on the same edge as clr_err keeps the flag set.
      stack_ovf <= ovf_s | (stack_ovf & ~clr_err);
      stack_unf <= unf_s | (stack_unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_i4040_sequencer.sv
// Self-checking bench for i4040_sequencer (ANIB=3, DEPTH=7, INT_VEC=3).
// A behavioural model (integer PC, queue-based stack, flags) is advanced on
// every rising edge and every output is compared after each edge.
module tb_i4040_sequencer;

  localparam int ANIB  = 3;
  localparam int DEPTH = 7;
  localparam int NSUB  = ANIB + 5;
  localparam int AW    = 4 * ANIB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    pc_op = 3'd0;
  logic [AW-1:0] target = '0;
  logic          intr = 1'b0;
  logic          stop = 1'b0;
  logic          clr_err = 1'b0;
  logic          sync;
  logic [2:0]    sub_idx;
  logic [3:0]    addr_nib;
  logic [AW-1:0] pc;
  logic [3:0]    sp;
  logic          int_en;
  logic          int_ack;
  logic          stop_ack;
  logic          stack_ovf;
  logic          stack_unf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_sub;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  bit            m_ie, m_stopped, m_ack, m_ovf, m_unf;

  i4040_sequencer #(
    .ANIB    (ANIB),
    .DEPTH   (DEPTH),
    .INT_VEC (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_op     (pc_op),
    .target    (target),
    .intr      (intr),
    .stop      (stop),
    .clr_err   (clr_err),
    .sync      (sync),
    .sub_idx   (sub_idx),
    .addr_nib  (addr_nib),
    .pc        (pc),
    .sp        (sp),
    .int_en    (int_en),
    .int_ack   (int_ack),
    .stop_ack  (stop_ack),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sub = 0; m_pc = '0; m_stk.delete();
    m_ie = 0; m_stopped = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic m_push(input logic [AW-1:0] v);
    if (m_stk.size() == DEPTH) begin
      void'(m_stk.pop_front());
      m_ovf = 1;
    end
    m_stk.push_back(v);
  endtask

  task automatic m_pop(output logic [AW-1:0] v);
    if (m_stk.size() == 0) begin
      m_unf = 1;
      v = '0;
    end else begin
      v = m_stk.pop_back();
    end
  endtask

  task automatic m_boundary();
    bit take;
    logic [AW-1:0] r;
    m_ack = 0;
    take = intr && m_ie && (m_stopped || pc_op == 3'd0 || pc_op == 3'd4 || pc_op == 3'd7);
    if (take) begin
      r = (m_stopped || pc_op == 3'd4) ? m_pc : m_pc + 12'd1;
      m_push(r);
      m_pc = 12'h003; m_ie = 0; m_ack = 1; m_stopped = 0;
    end else if (m_stopped) begin
      if (!stop) m_stopped = 0;
    end else begin
      case (pc_op)
        3'd0, 3'd7: m_pc = m_pc + 12'd1;
        3'd1: m_pc = target;
        3'd2: begin m_push(m_pc + 12'd1); m_pc = target; end
        3'd3: m_pop(m_pc);
        3'd4: ;
        3'd5: m_pc = {m_pc[AW-1:8], target[7:0]};
        default: begin m_pop(m_pc); m_ie = 1; end
      endcase
      if (stop) m_stopped = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_nib;
    exp_nib = (m_sub < ANIB) ? 4'((m_pc >> (4 * m_sub)) & 12'hF) : 4'd0;
    chk({tag, ".sub_idx"},  sub_idx,   m_sub);
    chk({tag, ".sync"},     sync,      (m_sub == NSUB - 1));
    chk({tag, ".addr_nib"}, addr_nib,  exp_nib);
    chk({tag, ".pc"},       pc,        m_pc);
    chk({tag, ".sp"},       sp,        m_stk.size());
    chk({tag, ".int_en"},   int_en,    m_ie);
    chk({tag, ".int_ack"},  int_ack,   m_ack);
    chk({tag, ".stop_ack"}, stop_ack,  m_stopped);
    chk({tag, ".ovf"},      stack_ovf, m_ovf);
    chk({tag, ".unf"},      stack_unf, m_unf);
  endtask

  task automatic edge_step(input string tag);
    @(posedge clk);
    if (clr_err) begin m_ovf = 0; m_unf = 0; end
    if (m_sub == NSUB - 1) m_boundary();
    m_sub = (m_sub + 1) % NSUB;
    #1;
    check_all(tag);
  endtask

  task automatic run_cycle(input string tag, input logic [2:0] op, input logic [AW-1:0] tgt,
                           input logic ir, input logic st, input logic ce);
    pc_op = op; target = tgt; intr = ir; stop = st; clr_err = ce;
    repeat (NSUB) edge_step(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".pc"},       pc,        0);
    chk({tag, ".sp"},       sp,        0);
    chk({tag, ".sub_idx"},  sub_idx,   0);
    chk({tag, ".sync"},     sync,      0);
    chk({tag, ".addr_nib"}, addr_nib,  0);
    chk({tag, ".int_en"},   int_en,    0);
    chk({tag, ".int_ack"},  int_ack,   0);
    chk({tag, ".stop_ack"}, stop_ack,  0);
    chk({tag, ".ovf"},      stack_ovf, 0);
    chk({tag, ".unf"},      stack_unf, 0);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;
    check_all("release");

    // Three NEXT cycles: nibbles 0,0,0 / 1,0,0 / 2,0,0
    repeat (3) run_cycle("next", 3'd0, '0, 0, 0, 0);
    chk("next3.pc", pc, 12'h003);

    // CALL / RET round trip
    run_cycle("jump", 3'd1, 12'h010, 0, 0, 0);
    run_cycle("call", 3'd2, 12'h123, 0, 0, 0);
    chk("call.pc", pc, 12'h123);
    chk("call.sp", sp, 1);
    run_cycle("ret", 3'd3, '0, 0, 0, 0);
    chk("ret.pc", pc, 12'h011);
    chk("ret.sp", sp, 0);

    // Overflow then underflow
    for (int i = 0; i < 8; i++) run_cycle("ovf_call", 3'd2, 12'($urandom_range(0, 4095)), 0, 0, 0);
    chk("ovf.flag", stack_ovf, 1);
    chk("ovf.sp", sp, DEPTH);
    for (int i = 0; i < 8; i++) run_cycle("unf_ret", 3'd3, '0, 0, 0, 0);
    chk("unf.pc", pc, 0);
    chk("unf.flag", stack_unf, 1);
    run_cycle("clr", 3'd0, '0, 0, 0, 1);
    chk("clr.ovf", stack_ovf, 0);

    // Interrupt deferral and entry
    run_cycle("reti_empty", 3'd6, '0, 0, 0, 0);
    chk("reti.int_en", int_en, 1);
    run_cycle("int_defer", 3'd1, 12'h040, 1, 0, 0);
    chk("defer.pc", pc, 12'h040);
    run_cycle("int_take", 3'd0, '0, 1, 0, 0);
    chk("take.pc", pc, 12'h003);
    chk("take.ack", int_ack, 1);
    chk("take.int_en", int_en, 0);
    run_cycle("in_isr", 3'd0, '0, 1, 0, 0);
    run_cycle("reti", 3'd6, '0, 0, 0, 0);
    chk("reti.pc", pc, 12'h041);

    // Stop / resume / wake by interrupt
    run_cycle("jump200", 3'd1, 12'h200, 0, 0, 0);
    run_cycle("stop", 3'd4, '0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle("stopped", 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 0, 1, 0);
    chk("stopped.pc", pc, 12'h200);
    run_cycle("resume", 3'd0, '0, 0, 0, 0);
    chk("resume.stop_ack", stop_ack, 0);
    run_cycle("stop2", 3'd4, '0, 0, 1, 0);
    run_cycle("wake", 3'd0, '0, 1, 1, 0);
    chk("wake.pc", pc, 12'h003);
    run_cycle("wake_ret", 3'd6, '0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      run_cycle("rand", 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a CALL
    pc_op = 3'd2; target = 12'h555; intr = 0; stop = 0; clr_err = 0;
    run_cycle("pre_mid", 3'd2, 12'h0F0, 0, 0, 0);
    pc_op = 3'd2;
    repeat (4) edge_step("mid");
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_cycle("after_reset", 3'd0, '0, 0, 0, 0);
    chk("after_reset.pc", pc, 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i4040_sequencer.md
I4040_SEQUENCER -- requirements
Module: i4040_sequencer

Interface
REQ-001 Parameter ANIB, 3, address nibbles; ANIB in 2..4, ADDR_W = 4*ANIB.
REQ-002 Parameter DEPTH, 7, call-stack entries, 1..15.
REQ-003 Parameter INT_VEC, 3, interrupt entry address, ADDR_W bits.
REQ-004 clk  input  1  subcycle clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 pc_op  input  3  PC command, sampled only at cycle boundary.
REQ-007 target  input  ADDR_W  jump/call destination.
REQ-008 intr  input  1  interrupt request, level.
REQ-009 stop  input  1  stop request, level.
REQ-010 clr_err  input  1  clears sticky stack flags.
REQ-011 sync  output  1  high during last subcycle of each instruction cycle.
REQ-012 sub_idx  output  3  current subcycle index.
REQ-013 addr_nib  output  4  PC nibble during address subcycles, else 0.
REQ-014 pc  output  ADDR_W  program counter.
REQ-015 sp  output  4  stack occupancy, 0..DEPTH.
REQ-016 int_en  output  1  interrupt enable.
REQ-017 int_ack  output  1  high for whole cycle after interrupt entry.
REQ-018 stop_ack  output  1  high while in STOPPED.
REQ-019 stack_ovf, stack_unf  output  1 each  sticky error flags.

Function
REQ-020 Instruction cycle SHALL be NSUB = ANIB+5 subcycles: A1..A(ANIB), M1, M2, X1, X2, X3; sub_idx counts 0..NSUB-1 and wraps.
REQ-021 sync SHALL be 1 exactly when sub_idx = NSUB-1 (boundary).
REQ-022 addr_nib SHALL output pc[4k+3:4k] when sub_idx = k < ANIB, low nibble first.
REQ-023 At boundary edge in RUN, pc_op SHALL apply: 0 NEXT pc+1; 1 JUMP pc<=target; 2 CALL push pc+1, pc<=target; 3 RET pop to pc; 4 HOLD pc unchanged; 5 PAGE pc<={pc[ADDR_W-1:8], target[7:0]}; 6 RETI pop to pc, int_en<=1; 7 NEXT.
REQ-024 pc increment SHALL wrap modulo 2^ADDR_W; off-boundary edges SHALL not change pc, stack, int_en.
REQ-025 Interrupt SHALL be accepted at boundary iff intr & int_en & pc_op in {NEXT,HOLD}: push resulting pc, pc<=INT_VEC, int_en<=0, int_ack=1 for next NSUB subcycles; else request deferred.
REQ-026 Interrupt priority SHALL exceed stop; intr accepted in STOPPED wakes to RUN.
REQ-027 States RUN, STOPPED: RUN->STOPPED at boundary when stop=1 and no interrupt accepted (pc_op still applied); STOPPED->RUN at boundary when stop=0; in STOPPED pc_op ignored, pc held, subcycles continue.
REQ-028 int_en SHALL be set only by RETI; pc_op 6 with empty stack still sets int_en.
REQ-029 Push at sp=DEPTH SHALL discard oldest entry, keep sp=DEPTH, set stack_ovf.
REQ-030 Pop at sp=0 SHALL load pc<=0, keep sp=0, set stack_unf.
REQ-031 clr_err SHALL clear flags on any edge; simultaneous new error SHALL win (flag stays 1).

Reset
REQ-032 reset low SHALL force immediately: pc=0, sp=0, stack entries 0, sub_idx=0, sync=0, int_en=0, int_ack=0, stop_ack=0, flags 0, state RUN; addr_nib=0.
REQ-033 Reset mid-cycle SHALL abandon the cycle; first edge after release begins from sub_idx 0 -> 1.

Structure
REQ-034 Package i40xx_pkg SHALL hold pc_op encodings and the RUN/STOPPED state type.
REQ-035 Call stack SHALL be sub-module pc_stack (push, pop, data, sp, ovf/unf strobes), parametrised by DEPTH and ADDR_W.

Verification
REQ-036 Reset release, pc_op=NEXT for 3 cycles, ANIB=3 -> addr_nib 0,0,0 then 1,0,0 then 2,0,0; sync every 8th edge.
REQ-037 CALL target 0x123 at pc 0x010, then RET -> pc 0x123, sp 1; then pc 0x011, sp 0.
REQ-038 8 CALLs with DEPTH=7 -> stack_ovf=1, sp=7; 7 RETs return the 7 newest addresses; 8th RET -> pc 0, stack_unf=1.
REQ-039 RETI to set int_en, intr=1 with pc_op=JUMP -> deferred; next NEXT at pc 0x040 -> pc 0x003, stack top 0x041, int_ack one cycle, int_en 0.
REQ-040 stop=1 at pc 0x200 -> stop_ack, pc held 3 cycles; stop=0 -> RUN next boundary; intr with int_en=1 during STOPPED -> pc 0x003.
REQ-041 reset asserted at sub_idx 4 during CALL -> all outputs at reset values immediately, sp 0.
